// File: rtl/mfp_uart_tx_pkg.sv
// rtl/mfp_uart_tx_pkg.sv - shared UART transmitter encodings and baud constants
package mfp_uart_tx_pkg;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

  localparam int UART_CLK_HZ       = 50_000_000;
  localparam int UART_BAUD         = 115_200;
  // 50 MHz / 115200 rounds down to 434 clocks per bit
  localparam int UART_CLKS_PER_BIT = UART_CLK_HZ / UART_BAUD;

endpackage

// File: rtl/mfp_sync_fifo.sv
// rtl/mfp_sync_fifo.sv - single-clock FIFO with registered full/empty flags
// Ports: clk, reset (sync, active-high); wr/wr_data push; rd pops the head
// shown on rd_data; full, empty, count reflect the stored entry count.
module mfp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr,
  input  logic             rd,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;
  logic [CNT_W-1:0] count_nxt;

  // full is the registered flag, so a write during a pop on a full FIFO is dropped
  assign do_wr   = wr && !full;
  assign do_rd   = rd && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_wr && !do_rd) begin
      count_nxt = count + 1'b1;
    end else if (!do_wr && do_rd) begin
      count_nxt = count - 1'b1;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mfp_uart_tx.sv
// rtl/mfp_uart_tx.sv - buffered 8N1 UART transmitter
// Ports: clk, reset (sync, active-high); tx_data/tx_wr enqueue a byte;
// ovf_clr clears the sticky tx_overflow; tx_full, tx_empty, fifo_count
// describe the queue; tx_busy covers queue and serialiser; UART_TX line out.
module mfp_uart_tx
  import mfp_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       tx_data,
  input  logic             tx_wr,
  input  logic             ovf_clr,
  output logic             tx_full,
  output logic             tx_empty,
  output logic             tx_busy,
  output logic             tx_overflow,
  output logic [CNT_W-1:0] fifo_count,
  output logic             UART_TX
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  uart_state_t state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;
  logic [7:0]  fifo_head;
  logic        baud_last;
  logic        pop;

  assign baud_last = (baud_cnt == BAUD_LAST);
  // Popping on the final stop cycle lets the next start bit follow with no gap
  assign pop       = !tx_empty &&
                     ((state == UART_IDLE) || (state == UART_STOP && baud_last));
  assign tx_busy   = (state != UART_IDLE) || !tx_empty;

  mfp_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_data (tx_data),
    .wr      (tx_wr),
    .rd      (pop),
    .rd_data (fifo_head),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (fifo_count)
  );

  // Set has priority over clear
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_overflow <= 1'b0;
    end else if (tx_wr && tx_full) begin
      tx_overflow <= 1'b1;
    end else if (ovf_clr) begin
      tx_overflow <= 1'b0;
    end
  end

  // UART_TX is loaded with the level of the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= UART_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      UART_TX   <= 1'b1;
    end else begin
      case (state)
        UART_IDLE: begin
          UART_TX  <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            shift_reg <= fifo_head;
            state     <= UART_START;
            UART_TX   <= 1'b0;
          end
        end
        UART_START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= UART_DATA;
            UART_TX  <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        UART_DATA: begin
          if (baud_last) begin
            baud_cnt  <= '0;
            shift_reg <= {1'b0, shift_reg[7:1]};
            if (bit_idx == 3'd7) begin
              state   <= UART_STOP;
              UART_TX <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              UART_TX <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        UART_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (pop) begin
              shift_reg <= fifo_head;
              state     <= UART_START;
              UART_TX   <= 1'b0;
            end else begin
              state   <= UART_IDLE;
              UART_TX <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          state   <= UART_IDLE;
          UART_TX <= 1'b1;
        end
      endcase
    end
  end

endmodule
